prince_sbox_cms_layer: RTL and testbench

Pipelined, first-order masked PRINCE S-box layer processing NIBBLES nibbles in parallel on a 4-share representation. Successor to the per-coordinate, per-share combinational functions: it adds width parametrisation, a two-stage registered pipeline with valid/ready flow control, and a fresh-randomness refresh stage. It sits between the masked key/round-constant addition and the masked linear layer of the PRINCE datapath.

---
 rtl/prince_sbox_cms_layer.sv | 176 +++++++++++++++++
 tb/tb_prince_sbox_cms_layer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prince_sbox_cms_layer.sv
// Pipelined first-order masked PRINCE S-box layer on 4 shares: non-complete sharing into stage 1, ring refresh into stage 2.
// Optional inverse S-box selection is compiled in with the PRINCE_SBOX_INV_EN macro.
module prince_sbox_cms_layer #(
    parameter int NIBBLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*NIBBLES-1:0] in_shares,
    input  logic [16*NIBBLES-1:0] rnd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*NIBBLES-1:0] out_shares
`ifdef PRINCE_SBOX_INV_EN
    ,
    input  logic                  inv
`endif
);
    localparam int SW = 4 * NIBBLES;
    localparam int W  = 16 * NIBBLES;

    localparam logic [63:0] SBOX_FWD = 64'h4D5E_0876_19CA_23FB;

    // Bit [16*c + m] is the algebraic-normal-form coefficient of monomial m in output bit c.
    function automatic logic [63:0] anf_of(input logic [63:0] sbox);
        logic [63:0] coef;
        logic        acc;
        coef = '0;
        for (int c = 0; c < 4; c++) begin
            for (int m = 0; m < 16; m++) begin
                acc = 1'b0;
                for (int x = 0; x < 16; x++) begin
                    if ((x & ~m & 15) == 0) begin
                        acc = acc ^ sbox[4*x + c];
                    end
                end
                coef[16*c + m] = acc;
            end
        end
        return coef;
    endfunction

    localparam logic [63:0] ANF_FWD = anf_of(SBOX_FWD);

`ifdef PRINCE_SBOX_INV_EN
    localparam logic [63:0] SBOX_INV = 64'h1CE5_046A_98DF_237B;
    localparam logic [63:0] ANF_INV  = anf_of(SBOX_INV);
`endif

    // x[4*j + v] is bit v of input share j; result [4*k + c] is bit c of output share k.
    // Each expanded monomial goes to the lowest share index it does not touch; the degree-4
    // monomial is skipped because its coefficient is zero for any bijective 4-bit S-box.
    function automatic logic [15:0] share_nibble(input logic [15:0] x, input logic [63:0] coef);
        logic [15:0] y;
        logic        term;
        logic [3:0]  used;
        int          k;
        y = '0;
        for (int c = 0; c < 4; c++) begin
            y[c] = coef[16*c];
            for (int m = 1; m < 15; m++) begin
                if (coef[16*c + m]) begin
                    for (int i0 = 0; i0 < (((m & 1) != 0) ? 4 : 1); i0++) begin
                        for (int i1 = 0; i1 < (((m & 2) != 0) ? 4 : 1); i1++) begin
                            for (int i2 = 0; i2 < (((m & 4) != 0) ? 4 : 1); i2++) begin
                                for (int i3 = 0; i3 < (((m & 8) != 0) ? 4 : 1); i3++) begin
                                    term = 1'b1;
                                    used = '0;
                                    if ((m & 1) != 0) begin
                                        term     = term & x[4*i0];
                                        used[i0] = 1'b1;
                                    end
                                    if ((m & 2) != 0) begin
                                        term     = term & x[4*i1 + 1];
                                        used[i1] = 1'b1;
                                    end
                                    if ((m & 4) != 0) begin
                                        term     = term & x[4*i2 + 2];
                                        used[i2] = 1'b1;
                                    end
                                    if ((m & 8) != 0) begin
                                        term     = term & x[4*i3 + 3];
                                        used[i3] = 1'b1;
                                    end
                                    if (!used[0]) begin
                                        k = 0;
                                    end else if (!used[1]) begin
                                        k = 1;
                                    end else if (!used[2]) begin
                                        k = 2;
                                    end else begin
                                        k = 3;
                                    end
                                    y[4*k + c] = y[4*k + c] ^ term;
                                end
                            end
                        end
                    end
                end
            end
        end
        return y;
    endfunction

    logic          s1_valid_q, s1_valid_d;
    logic          s2_valid_q, s2_valid_d;
    logic [W-1:0]  s1_shares_q, s1_shares_d;
    logic [W-1:0]  s2_shares_q, s2_shares_d;
    logic [W-1:0]  s1_calc;
    logic [W-1:0]  s2_calc;
    logic [63:0]   s1_coef;
    logic          s1_load;
    logic          s2_load;

    // The mode is folded into the stage-1 shares at acceptance, so each block carries its own S or S^-1.
`ifdef PRINCE_SBOX_INV_EN
    assign s1_coef = inv ? ANF_INV : ANF_FWD;
`else
    assign s1_coef = ANF_FWD;
`endif

    always_comb begin
        logic [15:0] nib_in;
        logic [15:0] nib_out;
        s1_calc = '0;
        nib_in  = '0;
        nib_out = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            for (int j = 0; j < 4; j++) begin
                nib_in[4*j +: 4] = in_shares[j*SW + 4*n +: 4];
            end
            nib_out = share_nibble(nib_in, s1_coef);
            for (int j = 0; j < 4; j++) begin
                s1_calc[j*SW + 4*n +: 4] = nib_out[4*j +: 4];
            end
        end
    end

    // Ring refresh: every r_j enters exactly two neighbouring shares, so the recombined value is unchanged.
    always_comb begin
        s2_calc = '0;
        for (int j = 0; j < 4; j++) begin
            s2_calc[j*SW +: SW] = s1_shares_q[j*SW +: SW] ^ rnd[j*SW +: SW]
                                ^ rnd[((j + 1) % 4)*SW +: SW];
        end
    end

    always_comb begin
        s2_load     = s1_valid_q && (!s2_valid_q || out_ready);
        in_ready    = !s1_valid_q || s2_load;
        s1_load     = in_valid && in_ready;
        s1_valid_d  = s1_load ? 1'b1 : (s2_load ? 1'b0 : s1_valid_q);
        s2_valid_d  = s2_load ? 1'b1 : (out_ready ? 1'b0 : s2_valid_q);
        s1_shares_d = s1_load ? s1_calc : s1_shares_q;
        s2_shares_d = s2_load ? s2_calc : s2_shares_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s1_shares_q <= '0;
            s2_shares_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            s1_shares_q <= s1_shares_d;
            s2_shares_q <= s2_shares_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_shares = s2_shares_q;

endmodule

// File: tb/tb_prince_sbox_cms_layer.sv
// Directed self-checking bench for prince_sbox_cms_layer: recombined values, latency, non-completeness,
// throughput, backpressure and mid-flight reset (plus inverse mode when PRINCE_SBOX_INV_EN is defined).
module tb_prince_sbox_cms_layer;
    localparam int NIBBLES = 16;
    localparam int W       = 16 * NIBBLES;

    localparam logic [3:0] S_FWD [16] = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
                                          4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};
    localparam logic [3:0] S_INV [16] = '{4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
                                          4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_shares;
    logic [W-1:0] rnd;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_shares;
`ifdef PRINCE_SBOX_INV_EN
    logic         in_inv;
`endif

    int           checks    = 0;
    int           errors    = 0;
    int           out_count = 0;
    bit           rnd_rand  = 1'b1;
    logic [63:0]  exp_q [$];
    logic [W-1:0] out_log [$];

    int           stalls;
    int           total_stalls;
    int           start_count;
    int           idx;
    int           accepted;
    logic [63:0]  bp_val [3];
    logic [W-1:0] bp_sh [3];
    logic [W-1:0] snap;
    logic [W-1:0] base_sh;
    logic [W-1:0] pair_a;
    logic [W-1:0] pair_b;
    logic [63:0]  flip;
    int           flip_share [16];

    prince_sbox_cms_layer #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_shares (in_shares),
        .rnd       (rnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_shares(out_shares)
`ifdef PRINCE_SBOX_INV_EN
        ,
        .inv       (in_inv)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] sbox_ref(input logic [63:0] v, input logic inv_sel);
        logic [63:0] r;
        r = '0;
        for (int n = 0; n < 16; n++) begin
            r[4*n +: 4] = inv_sel ? S_INV[v[4*n +: 4]] : S_FWD[v[4*n +: 4]];
        end
        return r;
    endfunction

    function automatic logic [63:0] recombine(input logic [W-1:0] sh);
        return sh[0 +: 64] ^ sh[64 +: 64] ^ sh[128 +: 64] ^ sh[192 +: 64];
    endfunction

    function automatic logic [W-1:0] mask_value(input logic [63:0] v);
        logic [63:0] r1, r2, r3;
        r1 = rand64();
        r2 = rand64();
        r3 = rand64();
        return {r3, r2, r1, v ^ r1 ^ r2 ^ r3};
    endfunction

    // Called at a falling edge; returns at the falling edge after the block is accepted.
    task automatic apply_stimulus(input logic [W-1:0] sh, input logic inv_sel, output int n_stall);
        in_shares = sh;
        in_valid  = 1'b1;
`ifdef PRINCE_SBOX_INV_EN
        in_inv    = inv_sel;
`endif
        n_stall = 0;
        #1;
        while (!in_ready && n_stall < 40) begin
            @(negedge clk);
            #1;
            n_stall++;
        end
        if (!in_ready) begin
            check_output("accept_timeout", W'(in_ready), W'(1));
        end else begin
            exp_q.push_back(sbox_ref(recombine(sh), inv_sel));
            @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            #2;
            n++;
        end
        check_output("drain", W'(exp_q.size()), '0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rnd_rand) begin
            for (int i = 0; i < 8; i++) begin
                rnd[32*i +: 32] = $urandom;
            end
        end
    end

    always @(negedge clk) begin
        logic [63:0] e;
        #1;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_out", W'(out_valid), '0);
            end else begin
                e = exp_q.pop_front();
                check_output("out_value", W'(recombine(out_shares)), W'(e));
            end
            out_log.push_back(out_shares);
            out_count++;
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_shares = '0;
        rnd       = '0;
        out_ready = 1'b1;
`ifdef PRINCE_SBOX_INV_EN
        in_inv    = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("reset_out_valid", W'(out_valid), '0);
        check_output("reset_out_shares", out_shares, '0);
        check_output("reset_in_ready", W'(in_ready), W'(1));

        // Known vector and two-register latency.
        @(negedge clk);
        apply_stimulus(mask_value(64'h0123_4567_89AB_CDEF), 1'b0, stalls);
        idle();
        #1;
        check_output("latency_after_accept_edge", W'(out_valid), '0);
        @(negedge clk);
        #1;
        check_output("latency_after_second_edge", W'(out_valid), W'(1));
        check_output("vector_0123", W'(recombine(out_shares)), W'(64'hBF32_AC91_6780_E5D4));
        @(negedge clk);
        wait_drain();

        // Non-completeness: with rnd frozen, output share j must not move when only input share j changes.
        rnd_rand = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rnd[32*i +: 32] = $urandom;
        end
        out_log.delete();
        for (int c = 0; c < 16; c++) begin
            flip_share[c] = c / 4;
            base_sh = mask_value(rand64());
            flip    = rand64() | 64'h1;
            apply_stimulus(base_sh, 1'b0, stalls);
            apply_stimulus(base_sh ^ (W'(flip) << (64 * flip_share[c])), 1'b0, stalls);
        end
        idle();
        wait_drain();
        check_output("noncomplete_count", W'(out_log.size()), W'(32));
        if (out_log.size() == 32) begin
            for (int c = 0; c < 16; c++) begin
                pair_a = out_log[2*c];
                pair_b = out_log[2*c + 1];
                check_output($sformatf("noncomplete_j%0d_case%0d", flip_share[c], c % 4),
                             W'(pair_b[64*flip_share[c] +: 64]), W'(pair_a[64*flip_share[c] +: 64]));
            end
        end
        rnd_rand = 1'b1;

        // 100 back-to-back blocks with out_ready held high.
        total_stalls = 0;
        start_count  = out_count;
        for (int i = 0; i < 100; i++) begin
            apply_stimulus(mask_value(rand64()), 1'b0, stalls);
            total_stalls += stalls;
        end
        idle();
        wait_drain();
        check_output("b2b_stalls", W'(total_stalls), '0);
        check_output("b2b_count", W'(out_count - start_count), W'(100));

        // Backpressure: 3 blocks offered over 5 stalled cycles.
        out_ready = 1'b0;
        idx       = 0;
        accepted  = 0;
        for (int i = 0; i < 3; i++) begin
            bp_val[i] = rand64();
            bp_sh[i]  = mask_value(bp_val[i]);
        end
        for (int cyc = 0; cyc < 5; cyc++) begin
            in_valid  = (idx < 3);
            in_shares = bp_sh[(idx < 3) ? idx : 2];
            #1;
            if (in_ready && idx < 3) begin
                exp_q.push_back(sbox_ref(bp_val[idx], 1'b0));
                idx++;
                accepted++;
            end
            @(negedge clk);
        end
        #1;
        snap = out_shares;
        check_output("bp_accepted", W'(accepted), W'(2));
        check_output("bp_in_ready", W'(in_ready), '0);
        check_output("bp_out_valid", W'(out_valid), W'(1));
        check_output("bp_head_value", W'(recombine(out_shares)), W'(sbox_ref(bp_val[0], 1'b0)));
        @(negedge clk);
        #1;
        check_output("bp_stable", out_shares, snap);
        @(negedge clk);
        out_ready = 1'b1;
        if (idx < 3) begin
            apply_stimulus(bp_sh[idx], 1'b0, stalls);
        end
        idle();
        wait_drain();

        // Reset with two blocks in flight.
        out_ready = 1'b0;
        apply_stimulus(mask_value(rand64()), 1'b0, stalls);
        apply_stimulus(mask_value(rand64()), 1'b0, stalls);
        idle();
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        #1;
        check_output("rst_out_valid", W'(out_valid), '0);
        check_output("rst_out_shares", out_shares, '0);
        check_output("rst_in_ready", W'(in_ready), W'(1));
        rst         = 1'b0;
        out_ready   = 1'b1;
        start_count = out_count;
        repeat (5) @(negedge clk);
        #2;
        check_output("rst_no_stale", W'(out_count - start_count), '0);
        @(negedge clk);
        apply_stimulus(mask_value(64'hFEDC_BA98_7654_3210), 1'b0, stalls);
        idle();
        wait_drain();

`ifdef PRINCE_SBOX_INV_EN
        // Alternating forward/inverse blocks in flight together.
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(mask_value(64'h0), i[0], stalls);
        end
        apply_stimulus(mask_value(64'h0123_4567_89AB_CDEF), 1'b1, stalls);
        idle();
        #1;
        @(negedge clk);
        #1;
        check_output("inv_vector_0123", W'(recombine(out_shares)), W'(64'hB732_FD89_A640_5EC1));
        @(negedge clk);
        wait_drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
